// File: rtl/mips_cpu.sv
// mips_cpu: single-cycle 32-bit MIPS-I integer core with CP0 exceptions and interrupts.
// Optional HI/LO multiply/divide unit is enabled by defining MULDIV_EN;
// without it those opcodes raise a reserved-instruction exception.
module mips_cpu #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC  = 32'h0000_4180,
  parameter logic [31:0] INTGEN_ADDR = 32'h0000_7F20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        interrupt,
  output logic [31:0] macroscopic_pc,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] m_data_addr,
  input  logic [31:0] m_data_rdata,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  output logic [31:0] m_int_addr,
  output logic [3:0]  m_int_byteen,
  output logic [31:0] m_inst_addr,
  output logic        w_grf_we,
  output logic [4:0]  w_grf_addr,
  output logic [31:0] w_grf_wdata,
  output logic [31:0] w_inst_addr
);

  logic [31:0] pc, epc;
  logic [31:0] grf [32];
  logic [5:0]  sr_im;
  logic        sr_exl, sr_ie;
  logic [4:0]  exc_code;

  logic [31:0] inst;
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, sh;
  logic [31:0] rs_v, rt_v, simm, zimm, pc4, br_tgt;
  logic [31:0] add_rr, sub_rr, add_ri, ls_addr;
  logic        ov_add, ov_sub, ov_addi;

  assign inst   = i_inst_rdata;
  assign op     = inst[31:26];
  assign rs     = inst[25:21];
  assign rt     = inst[20:16];
  assign rd     = inst[15:11];
  assign sh     = inst[10:6];
  assign fn     = inst[5:0];
  assign rs_v   = grf[rs];
  assign rt_v   = grf[rt];
  assign simm   = {{16{inst[15]}}, inst[15:0]};
  assign zimm   = {16'h0, inst[15:0]};
  assign pc4    = pc + 32'd4;
  assign br_tgt = pc4 + {simm[29:0], 2'b00};
  assign add_rr = rs_v + rt_v;
  assign sub_rr = rs_v - rt_v;
  assign add_ri = rs_v + simm;
  assign ls_addr = add_ri;
  assign ov_add  = (rs_v[31] == rt_v[31]) && (add_rr[31] != rs_v[31]);
  assign ov_sub  = (rs_v[31] != rt_v[31]) && (sub_rr[31] != rs_v[31]);
  assign ov_addi = (rs_v[31] == simm[31]) && (add_ri[31] != rs_v[31]);

  // CP0 read views; Cause.IP[12] mirrors the live interrupt line
  logic [31:0] sr_val, cause_val, cp0_rd;
  assign sr_val    = {16'h0, sr_im, 8'h0, sr_exl, sr_ie};
  assign cause_val = {16'h0, 3'b000, interrupt, 2'b00, 3'b000, exc_code, 2'b00};
  assign cp0_rd    = (rd == 5'd12) ? sr_val : (rd == 5'd13) ? cause_val :
                     (rd == 5'd14) ? epc : 32'h0;

  // Load/store lane handling; size comes straight from opcode bits [1:0]
  logic [1:0]  mem_size;
  logic        ld_unsigned, in_data, in_int, mis;
  logic [31:0] lrd, lshift, ld_val, st_wdata;
  logic [3:0]  st_be;
  assign mem_size    = op[1:0];
  assign ld_unsigned = op[2];
  assign in_data     = ls_addr < 32'h0000_3000;
  assign in_int      = ls_addr[31:2] == INTGEN_ADDR[31:2];
  assign mis         = ((mem_size == 2'b11) && (ls_addr[1:0] != 2'b00)) ||
                       ((mem_size == 2'b01) && ls_addr[0]);
  assign lrd         = in_int ? 32'h0 : m_data_rdata;
  assign lshift      = lrd >> {ls_addr[1:0], 3'b000};

  // Extend the selected load lane and place store data into its lane
  always_comb begin
    case (mem_size)
      2'b00: begin
        ld_val   = ld_unsigned ? {24'h0, lshift[7:0]} : {{24{lshift[7]}}, lshift[7:0]};
        st_be    = 4'b0001 << ls_addr[1:0];
        st_wdata = {24'h0, rt_v[7:0]} << {ls_addr[1:0], 3'b000};
      end
      2'b01: begin
        ld_val   = ld_unsigned ? {16'h0, lshift[15:0]} : {{16{lshift[15]}}, lshift[15:0]};
        st_be    = ls_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {16'h0, rt_v[15:0]} << {ls_addr[1], 4'b0000};
      end
      default: begin
        ld_val   = lrd;
        st_be    = 4'b1111;
        st_wdata = rt_v;
      end
    endcase
  end

`ifdef MULDIV_EN
  logic [31:0] hi, lo, hi_n, lo_n;
  logic        hilo_we;
  logic [63:0] prod_s, prod_u;
  logic signed [31:0] quo_s, rem_s;
  assign prod_s = $signed({{32{rs_v[31]}}, rs_v}) * $signed({{32{rt_v[31]}}, rt_v});
  assign prod_u = {32'h0, rs_v} * {32'h0, rt_v};
  assign quo_s  = $signed(rs_v) / $signed(rt_v);
  assign rem_s  = $signed(rs_v) % $signed(rt_v);
`endif

  logic        ri, sys, ov, is_ld, is_st, mtc0, eret, gwe;
  logic [4:0]  gaddr;
  logic [31:0] gdata, npc;

  // Instruction decode and execute
  always_comb begin
    ri = 1'b0; sys = 1'b0; ov = 1'b0; is_ld = 1'b0; is_st = 1'b0;
    mtc0 = 1'b0; eret = 1'b0; gwe = 1'b0; gaddr = rd; gdata = 32'h0; npc = pc4;
`ifdef MULDIV_EN
    hilo_we = 1'b0; hi_n = hi; lo_n = lo;
`endif
    case (op)
      6'b000000: begin
        case (fn)
          6'b000000: begin gwe = 1'b1; gdata = rt_v << sh; end
          6'b000010: begin gwe = 1'b1; gdata = rt_v >> sh; end
          6'b000011: begin gwe = 1'b1; gdata = $signed(rt_v) >>> sh; end
          6'b001000: npc = rs_v;
          6'b001001: begin gwe = 1'b1; gdata = pc4; npc = rs_v; end
          6'b001100: sys = 1'b1;
          6'b100000: begin gwe = 1'b1; gdata = add_rr; ov = ov_add; end
          6'b100001: begin gwe = 1'b1; gdata = add_rr; end
          6'b100010: begin gwe = 1'b1; gdata = sub_rr; ov = ov_sub; end
          6'b100011: begin gwe = 1'b1; gdata = sub_rr; end
          6'b100100: begin gwe = 1'b1; gdata = rs_v & rt_v; end
          6'b100101: begin gwe = 1'b1; gdata = rs_v | rt_v; end
          6'b100110: begin gwe = 1'b1; gdata = rs_v ^ rt_v; end
          6'b100111: begin gwe = 1'b1; gdata = ~(rs_v | rt_v); end
          6'b101010: begin gwe = 1'b1; gdata = {31'h0, $signed(rs_v) < $signed(rt_v)}; end
          6'b101011: begin gwe = 1'b1; gdata = {31'h0, rs_v < rt_v}; end
`ifdef MULDIV_EN
          6'b010000: begin gwe = 1'b1; gdata = hi; end
          6'b010010: begin gwe = 1'b1; gdata = lo; end
          6'b010001: begin hilo_we = 1'b1; hi_n = rs_v; end
          6'b010011: begin hilo_we = 1'b1; lo_n = rs_v; end
          6'b011000: begin hilo_we = 1'b1; {hi_n, lo_n} = prod_s; end
          6'b011001: begin hilo_we = 1'b1; {hi_n, lo_n} = prod_u; end
          6'b011010: if (rt_v != 32'h0) begin hilo_we = 1'b1; lo_n = quo_s; hi_n = rem_s; end
          6'b011011: if (rt_v != 32'h0) begin hilo_we = 1'b1; lo_n = rs_v / rt_v; hi_n = rs_v % rt_v; end
`endif
          default: ri = 1'b1;
        endcase
      end
      6'b000010: npc = {pc4[31:28], inst[25:0], 2'b00};
      6'b000011: begin npc = {pc4[31:28], inst[25:0], 2'b00}; gwe = 1'b1; gaddr = 5'd31; gdata = pc4; end
      6'b000100: if (rs_v == rt_v) npc = br_tgt;
      6'b000101: if (rs_v != rt_v) npc = br_tgt;
      6'b001000: begin gwe = 1'b1; gaddr = rt; gdata = add_ri; ov = ov_addi; end
      6'b001001: begin gwe = 1'b1; gaddr = rt; gdata = add_ri; end
      6'b001010: begin gwe = 1'b1; gaddr = rt; gdata = {31'h0, $signed(rs_v) < $signed(simm)}; end
      6'b001011: begin gwe = 1'b1; gaddr = rt; gdata = {31'h0, rs_v < simm}; end
      6'b001100: begin gwe = 1'b1; gaddr = rt; gdata = rs_v & zimm; end
      6'b001101: begin gwe = 1'b1; gaddr = rt; gdata = rs_v | zimm; end
      6'b001110: begin gwe = 1'b1; gaddr = rt; gdata = rs_v ^ zimm; end
      6'b001111: begin gwe = 1'b1; gaddr = rt; gdata = {inst[15:0], 16'h0}; end
      6'b010000: begin
        if (rs == 5'b00000) begin gwe = 1'b1; gaddr = rt; gdata = cp0_rd; end
        else if (rs == 5'b00100) mtc0 = 1'b1;
        else if (rs == 5'b10000 && fn == 6'b011000) begin eret = 1'b1; npc = epc; end
        else ri = 1'b1;
      end
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: begin
        is_ld = 1'b1; gwe = 1'b1; gaddr = rt; gdata = ld_val;
      end
      6'b101000, 6'b101001, 6'b101011: is_st = 1'b1;
      default: ri = 1'b1;
    endcase
  end

  logic irq, fetch_adel, adel_ld, ades, exc, commit;
  logic [4:0] code;
  assign irq        = sr_ie & ~sr_exl & sr_im[2] & interrupt;
  assign fetch_adel = (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFF);
  assign adel_ld    = is_ld && (mis || !(in_data || in_int));
  assign ades       = is_st && (mis || !(in_data || in_int));
  assign exc        = irq | fetch_adel | ri | sys | ov | adel_ld | ades;
  assign code       = irq ? 5'd0 : fetch_adel ? 5'd4 : ri ? 5'd10 : sys ? 5'd8 :
                      ov ? 5'd12 : adel_ld ? 5'd4 : 5'd5;
  assign commit     = ~exc & reset;

  assign macroscopic_pc = pc;
  assign i_inst_addr    = pc;
  assign m_inst_addr    = pc;
  assign w_inst_addr    = pc;
  assign m_data_addr    = ls_addr;
  assign m_int_addr     = ls_addr;
  assign m_data_wdata   = st_wdata;
  assign m_data_byteen  = (is_st && commit && in_data) ? st_be : 4'b0000;
  assign m_int_byteen   = (is_st && commit && in_int)  ? st_be : 4'b0000;
  assign w_grf_we       = gwe & commit;
  assign w_grf_addr     = gaddr;
  assign w_grf_wdata    = gdata;

  // PC and CP0 state: exceptions vector to the handler, otherwise follow decode
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC; epc <= 32'h0; sr_im <= 6'h0; sr_exl <= 1'b0; sr_ie <= 1'b0; exc_code <= 5'h0;
    end else if (exc) begin
      pc <= HANDLER_PC; epc <= pc; sr_exl <= 1'b1; exc_code <= code;
    end else begin
      pc <= npc;
      if (eret) sr_exl <= 1'b0;
      if (mtc0 && rd == 5'd12) begin sr_im <= rt_v[15:10]; sr_exl <= rt_v[1]; sr_ie <= rt_v[0]; end
      if (mtc0 && rd == 5'd14) epc <= rt_v;
    end
  end

  // Register file writeback; $0 stays hard-wired to zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) grf[i] <= 32'h0;
    end else if (gwe && !exc && gaddr != 5'd0) begin
      grf[gaddr] <= gdata;
    end
  end

`ifdef MULDIV_EN
  // HI/LO update, visible to mfhi/mflo on the following instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= 32'h0; lo <= 32'h0;
    end else if (hilo_we && !exc) begin
      hi <= hi_n; lo <= lo_n;
    end
  end
`endif

endmodule

// File: tb/tb_mips_cpu.sv
// tb_mips_cpu: directed program run on mips_cpu with instruction/data memory models.
module tb_mips_cpu;
  logic        clk, reset, interrupt;
  logic [31:0] macroscopic_pc, i_inst_addr, i_inst_rdata, m_data_addr, m_data_rdata;
  logic [31:0] m_data_wdata, m_int_addr, m_inst_addr, w_grf_wdata, w_inst_addr;
  logic [3:0]  m_data_byteen, m_int_byteen;
  logic        w_grf_we;
  logic [4:0]  w_grf_addr;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] imem [0:2047];
  logic [31:0] dmem [0:1023] = '{default: 32'h0};
  logic [31:0] ioff;

  mips_cpu dut (
    .clk(clk), .reset(reset), .interrupt(interrupt),
    .macroscopic_pc(macroscopic_pc), .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata),
    .m_data_addr(m_data_addr), .m_data_rdata(m_data_rdata), .m_data_wdata(m_data_wdata),
    .m_data_byteen(m_data_byteen), .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen),
    .m_inst_addr(m_inst_addr), .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr),
    .w_grf_wdata(w_grf_wdata), .w_inst_addr(w_inst_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ioff         = i_inst_addr - 32'h0000_3000;
  assign i_inst_rdata = (ioff < 32'h2000) ? imem[ioff[12:2]] : 32'h0;
  assign m_data_rdata = dmem[m_data_addr[11:2]];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (m_data_byteen[b]) dmem[m_data_addr[11:2]][8*b +: 8] <= m_data_wdata[8*b +: 8];
  end

  function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction
  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] c0(input logic [4:0] sel, input logic [4:0] rt, input logic [4:0] rd);
    return {6'b010000, sel, rt, rd, 11'h0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_wb(input string tag, input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".pc"}, macroscopic_pc, pc);
    chk({tag, ".we"}, {31'h0, w_grf_we}, 32'h1);
    chk({tag, ".addr"}, {27'h0, w_grf_addr}, {27'h0, a});
    chk({tag, ".data"}, w_grf_wdata, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    interrupt = 1'b0;
    for (int i = 0; i < 2048; i++) imem[i] = 32'h0;
    imem[0]  = i_op(6'b001101, 0, 1, 16'h1234);   // ori  $1,$0,0x1234
    imem[1]  = i_op(6'b001111, 0, 2, 16'hABCD);   // lui  $2,0xabcd
    imem[2]  = i_op(6'b101011, 0, 1, 16'h0000);   // sw   $1,0($0)
    imem[3]  = i_op(6'b001101, 0, 4, 16'h00CD);   // ori  $4,$0,0xcd
    imem[4]  = i_op(6'b101000, 0, 4, 16'h0005);   // sb   $4,5($0)
    imem[5]  = i_op(6'b100011, 0, 3, 16'h0004);   // lw   $3,4($0)
    imem[6]  = i_op(6'b100000, 0, 5, 16'h0005);   // lb   $5,5($0)
    imem[7]  = i_op(6'b000100, 0, 0, 16'h0001);   // beq  $0,$0,+1
    imem[8]  = i_op(6'b001101, 0, 6, 16'h0001);   // skipped
    imem[9]  = {6'b000011, 26'h0000C0B};          // jal  0x302c
    imem[10] = i_op(6'b001101, 0, 6, 16'h0002);   // skipped
    imem[11] = i_op(6'b001111, 0, 1, 16'h7FFF);   // lui  $1,0x7fff
    imem[12] = i_op(6'b001101, 1, 1, 16'hFFFF);   // ori  $1,$1,0xffff
    imem[13] = i_op(6'b001000, 1, 2, 16'h0001);   // addi $2,$1,1 -> Ov
    imem[14] = i_op(6'b001101, 0, 10, 16'h1401);  // ori  $10,$0,0x1401
    imem[15] = c0(5'b00100, 10, 12);              // mtc0 $10,SR
    imem[16] = i_op(6'b001101, 0, 11, 16'h0005);  // ori  $11,$0,5
    imem[17] = 32'hFC00_0000;                     // reserved opcode
    imem[18] = c0(5'b00000, 14, 12);              // mfc0 $14,SR
    imem[19] = i_op(6'b101011, 0, 1, 16'h0008);   // sw   $1,8($0)
    imem[1120] = c0(5'b00000, 7, 14);             // mfc0 $7,EPC
    imem[1121] = c0(5'b00000, 8, 13);             // mfc0 $8,Cause
    imem[1122] = i_op(6'b001100, 8, 9, 16'h007C); // andi $9,$8,0x7c
    imem[1123] = i_op(6'b000100, 9, 0, 16'h0001); // beq  $9,$0,+1 (interrupt: no skip)
    imem[1124] = i_op(6'b001001, 7, 7, 16'h0004); // addiu $7,$7,4
    imem[1125] = c0(5'b00100, 7, 14);             // mtc0 $7,EPC
    imem[1126] = i_op(6'b101000, 0, 4, 16'h7F20); // sb   $4,0x7f20($0)
    imem[1127] = 32'h4200_0018;                   // eret

    repeat (2) @(negedge clk);
    chk("rst.pc", macroscopic_pc, 32'h3000);
    chk("rst.we", {31'h0, w_grf_we}, 32'h0);
    chk("rst.byteen", {28'h0, m_data_byteen}, 32'h0);
    reset = 1'b1;
    #1;
    chk_wb("ori", 32'h3000, 5'd1, 32'h0000_1234);
    chk("ori.iaddr", i_inst_addr, 32'h3000);
    chk("ori.waddr", w_inst_addr, 32'h3000);
    chk("ori.maddr", m_inst_addr, 32'h3000);
    step; chk_wb("lui", 32'h3004, 5'd2, 32'hABCD_0000);
    step;
    chk("sw.byteen", {28'h0, m_data_byteen}, 32'hF);
    chk("sw.addr", m_data_addr, 32'h0);
    chk("sw.wdata", m_data_wdata, 32'h0000_1234);
    chk("sw.we", {31'h0, w_grf_we}, 32'h0);
    step; chk_wb("ori4", 32'h300C, 5'd4, 32'h0000_00CD);
    step;
    chk("sb.byteen", {28'h0, m_data_byteen}, 32'h2);
    chk("sb.addr", m_data_addr, 32'h5);
    chk("sb.wdata", m_data_wdata, 32'h0000_CD00);
    step; chk_wb("lw", 32'h3014, 5'd3, 32'h0000_CD00);
    step; chk_wb("lb", 32'h3018, 5'd5, 32'hFFFF_FFCD);
    step; chk("beq.pc", macroscopic_pc, 32'h301C);
    step; chk_wb("jal", 32'h3024, 5'd31, 32'h0000_3028);
    step; chk_wb("lui1", 32'h302C, 5'd1, 32'h7FFF_0000);
    step; chk_wb("ori1", 32'h3030, 5'd1, 32'h7FFF_FFFF);
    step;
    chk("ov.pc", macroscopic_pc, 32'h3034);
    chk("ov.we", {31'h0, w_grf_we}, 32'h0);
    step; chk_wb("ov.epc", 32'h4180, 5'd7, 32'h0000_3034);
    step; chk_wb("ov.cause", 32'h4184, 5'd8, 32'h0000_0030);
    step; step; step; chk_wb("ov.adv", 32'h4190, 5'd7, 32'h0000_3038);
    step; step;
    chk("ack1.int_be", {28'h0, m_int_byteen}, 32'h1);
    chk("ack1.data_be", {28'h0, m_data_byteen}, 32'h0);
    chk("ack1.addr", m_int_addr, 32'h7F20);
    chk("ack1.wdata", m_data_wdata, 32'h0000_00CD);
    step; chk("eret1.pc", macroscopic_pc, 32'h419C);
    step; chk_wb("ret1", 32'h3038, 5'd10, 32'h0000_1401);
    step; chk("mtc0.pc", macroscopic_pc, 32'h303C);
    step;
    interrupt = 1'b1;
    #1;
    chk("irq.pc", macroscopic_pc, 32'h3040);
    chk("irq.we", {31'h0, w_grf_we}, 32'h0);
    step; chk_wb("irq.epc", 32'h4180, 5'd7, 32'h0000_3040);
    step; chk_wb("irq.cause", 32'h4184, 5'd8, 32'h0000_1000);
    step; step; step; chk("irq.skip", macroscopic_pc, 32'h4194);
    step;
    chk("ack2.int_be", {28'h0, m_int_byteen}, 32'h1);
    chk("ack2.data_be", {28'h0, m_data_byteen}, 32'h0);
    step;
    interrupt = 1'b0;
    #1;
    chk("eret2.pc", macroscopic_pc, 32'h419C);
    step; chk_wb("ret2", 32'h3040, 5'd11, 32'h0000_0005);
    step;
    chk("ri.pc", macroscopic_pc, 32'h3044);
    chk("ri.we", {31'h0, w_grf_we}, 32'h0);
    step; chk_wb("ri.epc", 32'h4180, 5'd7, 32'h0000_3044);
    step; chk_wb("ri.cause", 32'h4184, 5'd8, 32'h0000_0028);
    step; step; step; step; step; step;
    step; chk_wb("sr.exl0", 32'h3048, 5'd14, 32'h0000_1401);
    step;
    chk("sw2.byteen", {28'h0, m_data_byteen}, 32'hF);
    chk("sw2.addr", m_data_addr, 32'h8);
    reset = 1'b0;
    #1;
    chk("rstmid.byteen", {28'h0, m_data_byteen}, 32'h0);
    chk("rstmid.we", {31'h0, w_grf_we}, 32'h0);
    chk("rstmid.pc", macroscopic_pc, 32'h3000);
    step;
    chk("rstmid.nostore", dmem[2], 32'h0);
    reset = 1'b1;
    #1;
    chk_wb("restart", 32'h3000, 5'd1, 32'h0000_1234);
    step; chk_wb("restart2", 32'h3004, 5'd2, 32'hABCD_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
